// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one combinational instruction memory between fetch (port 0) and debug/loader (port 1).
// Optional build macro IMEM_ARB_MISALIGN_EN adds p0_rsp_err/p1_rsp_err for addresses with addr[1:0] != 0.
module imem_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            p0_req_valid,
  output logic            p0_req_ready,
  input  logic [XLEN-1:0] p0_req_addr,
  output logic            p0_rsp_valid,
  input  logic            p0_rsp_ready,
  output logic [31:0]     p0_rsp_data,
  input  logic            p1_req_valid,
  output logic            p1_req_ready,
  input  logic [XLEN-1:0] p1_req_addr,
  output logic            p1_rsp_valid,
  input  logic            p1_rsp_ready,
  output logic [31:0]     p1_rsp_data,
`ifdef IMEM_ARB_MISALIGN_EN
  output logic            p0_rsp_err,
  output logic            p1_rsp_err,
`endif
  output logic [XLEN-1:0] mem_addr,
  input  logic [31:0]     mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t          state_q;
  logic            owner_q;
  logic [3:0]      starve_q;

  logic            owner_rsp_ready;
  logic            flush_kill;
  logic            grant_open;
  logic            p0_pick;
  logic            p1_pick;
  logic            accept;
  logic            win;
  logic [XLEN-1:0] win_addr;
  logic [31:0]     rd_word;

`ifdef IMEM_ARB_MISALIGN_EN
  logic            mis_q;
`endif

  always_comb begin
    owner_rsp_ready = owner_q ? p1_rsp_ready : p0_rsp_ready;
    // A flush only cancels a fetch-port access that is still in flight.
    flush_kill      = flush && !owner_q && (state_q == READ || state_q == RESP);
    grant_open      = reset_n && !flush_kill &&
                      (state_q == IDLE || (state_q == RESP && owner_rsp_ready));
    p1_pick         = p1_req_valid && (!p0_req_valid || starve_q == STARVE_LIM);
    p0_pick         = p0_req_valid && !p1_pick;
    p0_req_ready    = grant_open && p0_pick;
    p1_req_ready    = grant_open && p1_pick;
    accept          = p0_req_ready || p1_req_ready;
    win             = p1_req_ready;
    win_addr        = p1_req_ready ? p1_req_addr : p0_req_addr;
`ifdef IMEM_ARB_MISALIGN_EN
    rd_word         = mis_q ? '0 : mem_rdata;
`else
    rd_word         = mem_rdata;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      starve_q     <= '0;
      mem_addr     <= '0;
      p0_rsp_valid <= 1'b0;
      p1_rsp_valid <= 1'b0;
      p0_rsp_data  <= '0;
      p1_rsp_data  <= '0;
`ifdef IMEM_ARB_MISALIGN_EN
      mis_q        <= 1'b0;
      p0_rsp_err   <= 1'b0;
      p1_rsp_err   <= 1'b0;
`endif
    end else begin
      if (!p1_req_valid || p1_req_ready) begin
        starve_q <= '0;
      end else if (p0_req_ready && starve_q != STARVE_LIM) begin
        starve_q <= starve_q + 4'd1;
      end

      // Accepts only happen in IDLE or on a completing RESP, so the load is shared.
      if (accept) begin
        mem_addr <= win_addr;
        owner_q  <= win;
`ifdef IMEM_ARB_MISALIGN_EN
        mis_q    <= (win_addr[1:0] != 2'b00);
`endif
      end

      case (state_q)
        IDLE: begin
          if (accept) state_q <= READ;
        end
        READ: begin
          if (flush_kill) begin
            state_q <= IDLE;
          end else begin
            state_q <= RESP;
            if (owner_q) begin
              p1_rsp_valid <= 1'b1;
              p1_rsp_data  <= rd_word;
`ifdef IMEM_ARB_MISALIGN_EN
              p1_rsp_err   <= mis_q;
`endif
            end else begin
              p0_rsp_valid <= 1'b1;
              p0_rsp_data  <= rd_word;
`ifdef IMEM_ARB_MISALIGN_EN
              p0_rsp_err   <= mis_q;
`endif
            end
          end
        end
        RESP: begin
          if (flush_kill) begin
            state_q      <= IDLE;
            p0_rsp_valid <= 1'b0;
`ifdef IMEM_ARB_MISALIGN_EN
            p0_rsp_err   <= 1'b0;
`endif
          end else if (owner_rsp_ready) begin
            state_q <= accept ? READ : IDLE;
            if (owner_q) begin
              p1_rsp_valid <= 1'b0;
`ifdef IMEM_ARB_MISALIGN_EN
              p1_rsp_err   <= 1'b0;
`endif
            end else begin
              p0_rsp_valid <= 1'b0;
`ifdef IMEM_ARB_MISALIGN_EN
              p0_rsp_err   <= 1'b0;
`endif
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: per-cycle vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_imem_arbiter;

  localparam int XLEN = 32;
  localparam int SMAX = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            flush;
  logic            p0_req_valid, p0_req_ready, p0_rsp_valid, p0_rsp_ready;
  logic            p1_req_valid, p1_req_ready, p1_rsp_valid, p1_rsp_ready;
  logic [XLEN-1:0] p0_req_addr, p1_req_addr, mem_addr;
  logic [31:0]     p0_rsp_data, p1_rsp_data, mem_rdata;
`ifdef IMEM_ARB_MISALIGN_EN
  logic            p0_rsp_err, p1_rsp_err;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h8) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign mem_rdata = memf(mem_addr);

  imem_arbiter #(.XLEN(XLEN), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_addr(p0_req_addr),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rsp_data(p0_rsp_data),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_addr(p1_req_addr),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_rsp_data(p1_rsp_data),
`ifdef IMEM_ARB_MISALIGN_EN
    .p0_rsp_err(p0_rsp_err), .p1_rsp_err(p1_rsp_err),
`endif
    .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic [31:0] a0, input logic v1, input logic [31:0] a1,
                       input logic rr0, input logic rr1, input logic fl);
    @(negedge clk);
    p0_req_valid = v0; p0_req_addr = a0;
    p1_req_valid = v1; p1_req_addr = a1;
    p0_rsp_ready = rr0; p1_rsp_ready = rr1;
    flush = fl;
    #1;
  endtask

  // Transaction-level reference: at most one outstanding access, response visible
  // two cycles after acceptance, priority rule with a starvation count.
  logic        m_busy = 1'b0;
  logic        m_port = 1'b0;
  logic [31:0] m_data = '0;
  int          m_acc = 0;
  int          m_st = 0;
  int          cyc = 0;

  task automatic model_cycle(output logic g0, output logic g1);
    logic ev0, ev1, hs, open, w0, w1;
    ev0  = m_busy && !m_port && (cyc >= m_acc + 2);
    ev1  = m_busy &&  m_port && (cyc >= m_acc + 2);
    chk("m_p0_rsp_valid", p0_rsp_valid, ev0);
    chk("m_p1_rsp_valid", p1_rsp_valid, ev1);
    if (ev0) chk("m_p0_rsp_data", p0_rsp_data, m_data);
    if (ev1) chk("m_p1_rsp_data", p1_rsp_data, m_data);
    hs   = (ev0 && p0_rsp_ready) || (ev1 && p1_rsp_ready);
    open = !m_busy || hs;
    w1   = p1_req_valid && (!p0_req_valid || m_st == SMAX);
    w0   = p0_req_valid && !w1;
    g0   = open && w0;
    g1   = open && w1;
    chk("m_p0_req_ready", p0_req_ready, g0);
    chk("m_p1_req_ready", p1_req_ready, g1);
    if (hs) m_busy = 1'b0;
    if (g0 || g1) begin
      m_busy = 1'b1;
      m_port = g1;
      m_data = memf(g1 ? p1_req_addr : p0_req_addr);
      m_acc  = cyc;
    end
    if (!p1_req_valid || g1) m_st = 0;
    else if (g0 && m_st < SMAX) m_st++;
    cyc++;
  endtask

  typedef struct {
    logic        p0v; logic [31:0] p0a;
    logic        p1v; logic [31:0] p1a;
    logic        rr0, rr1, fl;
    logic        e0r, e1r, e0v, e1v;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic g0, g1;
    logic r0v, r1v;
    logic [31:0] r0a, r1a, a0, a1;
    int n;
    logic order[10];
    logic exp_order[10];

    reset_n = 1'b0; flush = 1'b0;
    p0_req_valid = 1'b0; p0_req_addr = '0; p0_rsp_ready = 1'b0;
    p1_req_valid = 1'b0; p1_req_addr = '0; p1_rsp_ready = 1'b0;
    #7;
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_p0_rsp_valid", p0_rsp_valid, 0);
    chk("rst_p1_rsp_valid", p1_rsp_valid, 0);
    chk("rst_p0_req_ready", p0_req_ready, 0);
    chk("rst_p1_req_ready", p1_req_ready, 0);
    chk("rst_p0_rsp_data", p0_rsp_data, 0);
    chk("rst_p1_rsp_data", p1_rsp_data, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single fetch, 5-cycle backpressure, release with immediate p1 grant.
    tbl[0]  = '{1'b1, 32'h8, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    for (int i = 2; i < 7; i++)
      tbl[i] = '{1'b0, 32'h0, 1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0050_0093};
    tbl[7]  = '{1'b0, 32'h0, 1'b1, 32'h20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0050_0093};
    tbl[8]  = '{1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, memf(32'h20)};
    tbl[10] = '{1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].p0v, tbl[i].p0a, tbl[i].p1v, tbl[i].p1a, tbl[i].rr0, tbl[i].rr1, tbl[i].fl);
      chk($sformatf("tbl%0d_p0_req_ready", i), p0_req_ready, tbl[i].e0r);
      chk($sformatf("tbl%0d_p1_req_ready", i), p1_req_ready, tbl[i].e1r);
      chk($sformatf("tbl%0d_p0_rsp_valid", i), p0_rsp_valid, tbl[i].e0v);
      chk($sformatf("tbl%0d_p1_rsp_valid", i), p1_rsp_valid, tbl[i].e1v);
      if (tbl[i].e0v) chk($sformatf("tbl%0d_p0_rsp_data", i), p0_rsp_data, tbl[i].ed);
      if (tbl[i].e1v) chk($sformatf("tbl%0d_p1_rsp_data", i), p1_rsp_data, tbl[i].ed);
    end

    // Flush during READ drops the fetch; a p1 request right after is served.
    drive(1, 32'h10, 0, 0, 1, 1, 0); chk("fl_accept", p0_req_ready, 1);
    drive(0, 0, 0, 0, 1, 1, 1);      chk("fl_read_mem_addr", mem_addr, 32'h10);
                                     chk("fl_read_ready", p0_req_ready, 0);
    drive(0, 0, 1, 32'h40, 1, 1, 0); chk("fl_no_rsp0", p0_rsp_valid, 0);
                                     chk("fl_idle_p1_ready", p1_req_ready, 1);
    drive(0, 0, 0, 0, 1, 1, 0);      chk("fl_no_rsp1", p0_rsp_valid, 0);
    drive(0, 0, 0, 0, 1, 1, 0);      chk("fl_p1_rsp_valid", p1_rsp_valid, 1);
                                     chk("fl_p1_rsp_data", p1_rsp_data, memf(32'h40));
                                     chk("fl_no_rsp2", p0_rsp_valid, 0);

    // Flush together with p0_rsp_ready in RESP: no accept that cycle, IDLE next.
    drive(1, 32'h14, 0, 0, 1, 1, 0); chk("flr_accept", p0_req_ready, 1);
    drive(1, 32'h18, 0, 0, 1, 1, 0); chk("flr_read_ready", p0_req_ready, 0);
    drive(1, 32'h18, 0, 0, 1, 1, 1); chk("flr_rsp_valid", p0_rsp_valid, 1);
                                     chk("flr_flush_no_accept", p0_req_ready, 0);
    drive(1, 32'h18, 0, 0, 1, 1, 0); chk("flr_after_valid", p0_rsp_valid, 0);
                                     chk("flr_idle_ready", p0_req_ready, 1);
    drive(0, 0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 1, 1, 0);      chk("flr_next_data", p0_rsp_data, memf(32'h18));

    // Flush has no effect on a port-1 access.
    drive(0, 0, 1, 32'h44, 1, 1, 0); chk("flp1_accept", p1_req_ready, 1);
    drive(0, 0, 0, 0, 1, 1, 1);
    drive(0, 0, 0, 0, 1, 1, 1);      chk("flp1_rsp_valid", p1_rsp_valid, 1);
                                     chk("flp1_rsp_data", p1_rsp_data, memf(32'h44));
    drive(0, 0, 0, 0, 1, 1, 0);      chk("flp1_done", p1_rsp_valid, 0);

    // Contention: both valid every cycle, expected grants p0 x4 then p1, repeating.
    exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    a0 = 32'h100; a1 = 32'h200; n = 0;
    for (int c = 0; c < 80 && n < 10; c++) begin
      drive(1, a0, 1, a1, 1, 1, 0);
      model_cycle(g0, g1);
      if (g0 && n < 10) begin order[n] = 1'b0; n++; a0 += 32'd4; end
      if (g1 && n < 10) begin order[n] = 1'b1; n++; a1 += 32'd4; end
    end
    chk("cont_grant_count", n, 10);
    for (int i = 0; i < n; i++) chk($sformatf("cont_grant%0d", i), order[i], exp_order[i]);

    // Randomized traffic; requesters hold valid/addr until accepted.
    r0v = 1'b0; r1v = 1'b0; r0a = '0; r1a = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!r0v && $urandom_range(1, 0) == 1) begin r0v = 1'b1; r0a = $urandom & 32'hFFFF_FFFC; end
      if (!r1v && $urandom_range(2, 0) == 0) begin r1v = 1'b1; r1a = $urandom & 32'hFFFF_FFFC; end
      drive(r0v, r0a, r1v, r1a, $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0, 1'b0);
      model_cycle(g0, g1);
      if (g0) r0v = 1'b0;
      if (g1) r1v = 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 1, 1, 0);
      model_cycle(g0, g1);
    end

    // Async reset while in RESP, then a fresh fetch with 2-cycle latency.
    drive(1, 32'h30, 0, 0, 0, 1, 0); chk("rs_accept", p0_req_ready, 1);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);      chk("rs_in_resp", p0_rsp_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rs_p0_rsp_valid", p0_rsp_valid, 0);
    chk("rs_p1_rsp_valid", p1_rsp_valid, 0);
    chk("rs_mem_addr", mem_addr, 0);
    chk("rs_p0_rsp_data", p0_rsp_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1, 32'h34, 0, 0, 1, 1, 0); chk("rs2_accept", p0_req_ready, 1);
    drive(0, 0, 0, 0, 1, 1, 0);      chk("rs2_lat1", p0_rsp_valid, 0);
    drive(0, 0, 0, 0, 1, 1, 0);      chk("rs2_lat2", p0_rsp_valid, 1);
                                     chk("rs2_data", p0_rsp_data, memf(32'h34));
    drive(0, 0, 0, 0, 1, 1, 0);

`ifdef IMEM_ARB_MISALIGN_EN
    drive(0, 0, 1, 32'h6, 1, 1, 0);  chk("mis_accept", p1_req_ready, 1);
    drive(0, 0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 1, 1, 0);      chk("mis_valid", p1_rsp_valid, 1);
                                     chk("mis_err", p1_rsp_err, 1);
                                     chk("mis_data", p1_rsp_data, 0);
    drive(0, 0, 1, 32'h4, 1, 1, 0);  chk("al_accept", p1_req_ready, 1);
    drive(0, 0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 1, 1, 0);      chk("al_valid", p1_rsp_valid, 1);
                                     chk("al_err", p1_rsp_err, 0);
                                     chk("al_data", p1_rsp_data, memf(32'h4));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
